// File: rtl/rotary_volume_reader.sv
// rtl/rotary_volume_reader.sv - services the rotary encoder event register and
// turns quadrature transitions into a saturating volume level.
module rotary_volume_reader #(
  parameter int QSTEPS_PER_DETENT = 4,
  parameter int VOL_W             = 8,
  parameter int VOL_MAX           = 255,
  parameter int VOL_STEP          = 4,
  parameter int VOL_RESET         = 64,
  parameter int IDLE_TIMEOUT      = 2400000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_state_change,
  input  logic [7:0]       rotary_encoder_reg,
  output logic             rotary_encoder_rd_stb,
  output logic [VOL_W-1:0] volume,
  output logic             volume_change_stb,
  output logic             volume_at_limit,
  output logic             reg_error,
  output logic [15:0]      event_count
);

  localparam int AW  = $clog2(QSTEPS_PER_DETENT) + 2;
  localparam int VW1 = VOL_W + 1;
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic signed [AW-1:0] Q_POS     = AW'(QSTEPS_PER_DETENT);
  localparam logic signed [AW-1:0] Q_NEG     = AW'(-QSTEPS_PER_DETENT);
  localparam logic [VW1-1:0]       STEP_W    = VW1'(VOL_STEP);
  localparam logic [VW1-1:0]       MAX_W     = VW1'(VOL_MAX);
  localparam logic [VOL_W-1:0]     MAX_N     = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0]     RST_VOL   = VOL_W'(VOL_RESET);
  localparam logic                 RST_LIMIT = (VOL_RESET == 0) || (VOL_RESET == VOL_MAX);
  localparam logic [TW-1:0]        T_MAX     = TW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, SETTLE} state_t;

  state_t                 state, state_next;
  logic [1:0]             last_value;
  logic signed [AW-1:0]   acc, acc_sum, step;
  logic [TW-1:0]          idle_cnt;
  logic [VW1-1:0]         vol_wide, vol_calc;
  logic [VOL_W-1:0]       vol_next;
  logic                   capture, accepted, cw, detent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next            = state;
    rotary_encoder_rd_stb = 1'b0;
    case (state)
      IDLE:    if (enc_state_change) state_next = CAPTURE;
      CAPTURE: state_next = ACK;
      ACK: begin
        rotary_encoder_rd_stb = 1'b1;
        state_next            = SETTLE;
      end
      // Writer gives set priority over clear, so a flag still high here is a new event.
      SETTLE:  state_next = enc_state_change ? CAPTURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign capture  = (state == CAPTURE);
  assign cw       = rotary_encoder_reg[2];
  assign accepted = capture && (rotary_encoder_reg[1:0] != last_value);

  always_comb begin
    step = cw ? AW'(1) : {AW{1'b1}};
    // A reversal against a partial detent restarts the count in the new direction.
    if (acc != '0 && acc[AW-1] != step[AW-1]) acc_sum = step;
    else                                      acc_sum = acc + step;
    detent   = (acc_sum == Q_POS) || (acc_sum == Q_NEG);
    vol_wide = {1'b0, volume};
    if (cw) begin
      vol_calc = vol_wide + STEP_W;
      if (vol_calc > MAX_W) vol_calc = MAX_W;
    end else if (vol_wide < STEP_W) begin
      vol_calc = '0;
    end else begin
      vol_calc = vol_wide - STEP_W;
    end
    vol_next = vol_calc[VOL_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_value        <= 2'b00;
      acc               <= '0;
      idle_cnt          <= '0;
      volume            <= RST_VOL;
      volume_change_stb <= 1'b0;
      volume_at_limit   <= RST_LIMIT;
      reg_error         <= 1'b0;
      event_count       <= '0;
    end else begin
      volume_change_stb <= 1'b0;
      if (capture && (rotary_encoder_reg[7:3] != 5'd0)) reg_error <= 1'b1;
      if (accepted) begin
        last_value  <= rotary_encoder_reg[1:0];
        event_count <= event_count + 16'd1;
        idle_cnt    <= '0;
        if (detent) begin
          acc               <= '0;
          volume            <= vol_next;
          volume_at_limit   <= (vol_next == '0) || (vol_next == MAX_N);
          volume_change_stb <= (vol_next != volume);
        end else begin
          acc <= acc_sum;
        end
      end else if (idle_cnt != T_MAX) begin
        idle_cnt <= idle_cnt + TW'(1);
      end else if (acc != '0) begin
        acc <= '0;
      end
    end
  end

endmodule
